// File: rtl/axi4_protocol_checker.sv
// axi4_protocol_checker: passive AXI4 monitor flagging handshake, burst-length, response and timeout violations
// Ports: ACLK/ARESETn clock and async active-low reset; AW/W/B/AR/R channel signals are all observed inputs;
//        err_clr clears the sticky err_flags; err_pulse strobes for one cycle on any new error;
//        wr_done_cnt/rd_done_cnt count completed write/read bursts.
module axi4_protocol_checker #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 4,
  parameter int B_TIMEOUT = 16,
  parameter int CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  input  logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic              WVALID,
  input  logic              WREADY,
  input  logic              WLAST,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              BVALID,
  input  logic              BREADY,
  input  logic [1:0]        BRESP,
  input  logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic              RLAST,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              err_clr,
  output logic [9:0]        err_flags,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  wr_done_cnt,
  output logic [CNT_W-1:0]  rd_done_cnt
);
  localparam int PW  = $clog2(MAX_OUT);
  localparam int CW  = PW + 1;
  localparam int TW  = $clog2(B_TIMEOUT + 1);
  localparam int AWP = ADDR_W + 8;
  localparam int WP  = DATA_W + 1;
  localparam int RP  = DATA_W + 3;

  logic [7:0]        wq_mem_q [MAX_OUT];
  logic [7:0]        wq_mem_d [MAX_OUT];
  logic [7:0]        rq_mem_q [MAX_OUT];
  logic [7:0]        rq_mem_d [MAX_OUT];
  logic [PW-1:0]     wq_rd_q, wq_rd_d, wq_wr_q, wq_wr_d, rq_rd_q, rq_rd_d, rq_wr_q, rq_wr_d;
  logic [CW-1:0]     wq_cnt_q, wq_cnt_d, rq_cnt_q, rq_cnt_d, pb_q, pb_d;
  logic [7:0]        wbeat_q, wbeat_d, rbeat_q, rbeat_d;
  logic [TW-1:0]     bt_q, bt_d;
  logic              aws_q, aws_d, ws_q, ws_d, ars_q, ars_d, rs_q, rs_d, bs_q, bs_d;
  logic [AWP-1:0]    awp_q, awp_d, arp_q, arp_d;
  logic [WP-1:0]     wp_q, wp_d;
  logic [RP-1:0]     rp_q, rp_d;
  logic [1:0]        bp_q, bp_d;
  logic [9:0]        err_q, err_d, det;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  wrc_q, wrc_d, rdc_q, rdc_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wq_empty, wq_full, rq_empty, rq_full;
  logic w_ok, w_pop, w_push, r_ok, r_pop, r_push;
  logic pb_zero, b_ok, pb_inc, bt_run;
  logic [7:0] w_head, r_head;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  assign wq_empty = wq_cnt_q == '0;
  assign wq_full  = wq_cnt_q == CW'(MAX_OUT);
  assign rq_empty = rq_cnt_q == '0;
  assign rq_full  = rq_cnt_q == CW'(MAX_OUT);

  // An empty queue is bypassed by a same-cycle address handshake; the
  // incoming length is still written and immediately read back out.
  assign w_ok   = w_hs & (~wq_empty | aw_hs);
  assign w_head = wq_empty ? AWLEN : wq_mem_q[wq_rd_q];
  assign w_pop  = w_ok & WLAST;
  assign w_push = aw_hs & (~wq_full | w_pop);
  assign r_ok   = r_hs & (~rq_empty | ar_hs);
  assign r_head = rq_empty ? ARLEN : rq_mem_q[rq_rd_q];
  assign r_pop  = r_ok & RLAST;
  assign r_push = ar_hs & (~rq_full | r_pop);

  assign pb_zero = pb_q == '0;
  assign b_ok    = b_hs & ~pb_zero;
  // Pending-B saturates rather than wrapping to zero.
  assign pb_inc  = w_pop & (pb_q != '1 | b_ok);
  assign bt_run  = ~pb_zero & ~BVALID;

  assign det = {
    (r_hs & rq_empty & ~ar_hs) | (r_ok & (RLAST != (rbeat_q == r_head))) |
      (ar_hs & rq_full & ~r_pop) | (b_hs & pb_zero),
    (BVALID & BRESP[0]) | (RVALID & RRESP[0]),
    bt_run & (bt_q == TW'(B_TIMEOUT - 1)),
    (w_hs & wq_empty & ~aw_hs) | (aw_hs & wq_full & ~w_pop),
    w_ok & (WLAST != (wbeat_q == w_head)),
    bs_q & (~BVALID | BRESP != bp_q),
    rs_q & (~RVALID | {RDATA, RRESP, RLAST} != rp_q),
    ars_q & (~ARVALID | {ARADDR, ARLEN} != arp_q),
    ws_q & (~WVALID | {WDATA, WLAST} != wp_q),
    aws_q & (~AWVALID | {AWADDR, AWLEN} != awp_q)
  };

  always_comb begin
    wq_mem_d = wq_mem_q;
    rq_mem_d = rq_mem_q;
    if (w_push) wq_mem_d[wq_wr_q] = AWLEN;
    if (r_push) rq_mem_d[rq_wr_q] = ARLEN;
  end

  assign wq_wr_d  = wq_wr_q + PW'(w_push);
  assign wq_rd_d  = wq_rd_q + PW'(w_pop);
  assign wq_cnt_d = wq_cnt_q + CW'(w_push) - CW'(w_pop);
  assign rq_wr_d  = rq_wr_q + PW'(r_push);
  assign rq_rd_d  = rq_rd_q + PW'(r_pop);
  assign rq_cnt_d = rq_cnt_q + CW'(r_push) - CW'(r_pop);
  assign wbeat_d  = w_ok ? (WLAST ? '0 : wbeat_q + 8'd1) : wbeat_q;
  assign rbeat_d  = r_ok ? (RLAST ? '0 : rbeat_q + 8'd1) : rbeat_q;
  assign pb_d     = pb_q + CW'(pb_inc) - CW'(b_ok);
  // Timer saturates at B_TIMEOUT so the timeout fires only once per wait.
  assign bt_d     = (b_hs | pb_zero) ? '0 :
                    (bt_run & bt_q != TW'(B_TIMEOUT)) ? bt_q + TW'(1) : bt_q;
  assign aws_d    = AWVALID & ~AWREADY;
  assign ws_d     = WVALID & ~WREADY;
  assign ars_d    = ARVALID & ~ARREADY;
  assign rs_d     = RVALID & ~RREADY;
  assign bs_d     = BVALID & ~BREADY;
  assign awp_d    = {AWADDR, AWLEN};
  assign wp_d     = {WDATA, WLAST};
  assign arp_d    = {ARADDR, ARLEN};
  assign rp_d     = {RDATA, RRESP, RLAST};
  assign bp_d     = BRESP;
  assign err_d    = (err_clr ? '0 : err_q) | det;
  assign pulse_d  = |det;
  assign wrc_d    = wrc_q + CNT_W'(b_ok);
  assign rdc_d    = rdc_q + CNT_W'(r_pop);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wq_mem_q <= '{default: '0};
      rq_mem_q <= '{default: '0};
      wq_rd_q  <= '0;
      wq_wr_q  <= '0;
      wq_cnt_q <= '0;
      rq_rd_q  <= '0;
      rq_wr_q  <= '0;
      rq_cnt_q <= '0;
      wbeat_q  <= '0;
      rbeat_q  <= '0;
      pb_q     <= '0;
      bt_q     <= '0;
      aws_q    <= 1'b0;
      ws_q     <= 1'b0;
      ars_q    <= 1'b0;
      rs_q     <= 1'b0;
      bs_q     <= 1'b0;
      awp_q    <= '0;
      wp_q     <= '0;
      arp_q    <= '0;
      rp_q     <= '0;
      bp_q     <= '0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
      wrc_q    <= '0;
      rdc_q    <= '0;
    end else begin
      wq_mem_q <= wq_mem_d;
      rq_mem_q <= rq_mem_d;
      wq_rd_q  <= wq_rd_d;
      wq_wr_q  <= wq_wr_d;
      wq_cnt_q <= wq_cnt_d;
      rq_rd_q  <= rq_rd_d;
      rq_wr_q  <= rq_wr_d;
      rq_cnt_q <= rq_cnt_d;
      wbeat_q  <= wbeat_d;
      rbeat_q  <= rbeat_d;
      pb_q     <= pb_d;
      bt_q     <= bt_d;
      aws_q    <= aws_d;
      ws_q     <= ws_d;
      ars_q    <= ars_d;
      rs_q     <= rs_d;
      bs_q     <= bs_d;
      awp_q    <= awp_d;
      wp_q     <= wp_d;
      arp_q    <= arp_d;
      rp_q     <= rp_d;
      bp_q     <= bp_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      wrc_q    <= wrc_d;
      rdc_q    <= rdc_d;
    end
  end

  assign err_flags   = err_q;
  assign err_pulse   = pulse_q;
  assign wr_done_cnt = wrc_q;
  assign rd_done_cnt = rdc_q;
endmodule

// File: tb/tb_axi4_protocol_checker.sv
// tb_axi4_protocol_checker: directed and random checks of axi4_protocol_checker against a queue-based model
module tb_axi4_protocol_checker;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_OUT = 4, B_TIMEOUT = 16, CNT_W = 16;

  logic ACLK, ARESETn;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr, err_pulse;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [7:0] AWLEN, ARLEN;
  logic [1:0] BRESP, RRESP;
  logic [9:0] err_flags;
  logic [CNT_W-1:0] wr_done_cnt, rd_done_cnt;

  axi4_protocol_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT),
    .B_TIMEOUT(B_TIMEOUT), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA), .RRESP(RRESP),
    .err_clr(err_clr), .err_flags(err_flags), .err_pulse(err_pulse),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp, n_bad;

  logic [9:0] m_flags;
  logic m_pulse;
  logic [CNT_W-1:0] m_wr, m_rd;
  int wq[$], rq[$];
  logic [7:0] m_wbeat, m_rbeat;
  int m_pend, m_bt;
  logic s_aw, s_w, s_ar, s_r, s_b;
  logic [ADDR_W+7:0] p_aw, p_ar;
  logic [DATA_W:0] p_w;
  logic [DATA_W+2:0] p_r;
  logic [1:0] p_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0; m_pulse = 1'b0; m_wr = '0; m_rd = '0;
    wq.delete(); rq.delete();
    m_wbeat = '0; m_rbeat = '0; m_pend = 0; m_bt = 0;
    s_aw = 0; s_w = 0; s_ar = 0; s_r = 0; s_b = 0;
    p_aw = '0; p_ar = '0; p_w = '0; p_r = '0; p_b = '0;
  endtask

  // Applies the protocol rules to the inputs present at this rising edge.
  task automatic model_tick();
    logic [9:0] d;
    bit awh, wh, bh, arh, rh, wpop, wcons, rcons;
    int head, pend0;
    if (!ARESETn) begin
      model_reset();
      return;
    end
    d = '0;
    awh = AWVALID && AWREADY; wh = WVALID && WREADY; bh = BVALID && BREADY;
    arh = ARVALID && ARREADY; rh = RVALID && RREADY;
    if (s_aw && (!AWVALID || {AWADDR, AWLEN} !== p_aw)) d[0] = 1'b1;
    if (s_w && (!WVALID || {WDATA, WLAST} !== p_w)) d[1] = 1'b1;
    if (s_ar && (!ARVALID || {ARADDR, ARLEN} !== p_ar)) d[2] = 1'b1;
    if (s_r && (!RVALID || {RDATA, RRESP, RLAST} !== p_r)) d[3] = 1'b1;
    if (s_b && (!BVALID || BRESP !== p_b)) d[4] = 1'b1;
    wpop = 0; wcons = 0;
    if (wh) begin
      if (wq.size() == 0 && !awh) d[6] = 1'b1;
      else begin
        head = (wq.size() != 0) ? wq[0] : int'(AWLEN);
        if (WLAST != (int'(m_wbeat) == head)) d[5] = 1'b1;
        if (WLAST) begin
          wpop = 1; m_wbeat = '0;
          if (wq.size() != 0) void'(wq.pop_front()); else wcons = 1;
        end else m_wbeat++;
      end
    end
    if (awh && !wcons) begin
      if (wq.size() < MAX_OUT) wq.push_back(int'(AWLEN)); else d[6] = 1'b1;
    end
    pend0 = m_pend;
    if (bh) begin
      if (pend0 == 0) d[9] = 1'b1; else m_wr++;
    end
    m_pend = pend0 + (wpop ? 1 : 0) - ((bh && pend0 != 0) ? 1 : 0);
    if (m_pend > 2 * MAX_OUT - 1) m_pend = 2 * MAX_OUT - 1;
    if (bh || pend0 == 0) m_bt = 0;
    else if (!BVALID && m_bt < B_TIMEOUT) begin
      m_bt++;
      if (m_bt == B_TIMEOUT) d[7] = 1'b1;
    end
    if ((BVALID && BRESP[0]) || (RVALID && RRESP[0])) d[8] = 1'b1;
    rcons = 0;
    if (rh) begin
      if (rq.size() == 0 && !arh) d[9] = 1'b1;
      else begin
        head = (rq.size() != 0) ? rq[0] : int'(ARLEN);
        if (RLAST != (int'(m_rbeat) == head)) d[9] = 1'b1;
        if (RLAST) begin
          m_rd++; m_rbeat = '0;
          if (rq.size() != 0) void'(rq.pop_front()); else rcons = 1;
        end else m_rbeat++;
      end
    end
    if (arh && !rcons) begin
      if (rq.size() < MAX_OUT) rq.push_back(int'(ARLEN)); else d[9] = 1'b1;
    end
    s_aw = AWVALID && !AWREADY; p_aw = {AWADDR, AWLEN};
    s_w  = WVALID && !WREADY;   p_w  = {WDATA, WLAST};
    s_ar = ARVALID && !ARREADY; p_ar = {ARADDR, ARLEN};
    s_r  = RVALID && !RREADY;   p_r  = {RDATA, RRESP, RLAST};
    s_b  = BVALID && !BREADY;   p_b  = BRESP;
    m_flags = (err_clr ? 10'h0 : m_flags) | d;
    m_pulse = |d;
  endtask

  task automatic step();
    @(posedge ACLK);
    model_tick();
    #1;
    chk("flags", 64'(err_flags), 64'(m_flags));
    chk("pulse", 64'(err_pulse), 64'(m_pulse));
    chk("wr_cnt", 64'(wr_done_cnt), 64'(m_wr));
    chk("rd_cnt", 64'(rd_done_cnt), 64'(m_rd));
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; AWADDR = '0; AWLEN = '0;
    WVALID = 0; WREADY = 0; WLAST = 0; WDATA = '0;
    BVALID = 0; BREADY = 0; BRESP = '0;
    ARVALID = 0; ARREADY = 0; ARADDR = '0; ARLEN = '0;
    RVALID = 0; RREADY = 0; RLAST = 0; RDATA = '0; RRESP = '0;
    err_clr = 0;
  endtask

  task automatic set_aw(input logic v, input logic rd, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    AWVALID = v; AWREADY = rd; AWADDR = a; AWLEN = l;
  endtask
  task automatic set_w(input logic v, input logic rd, input logic [DATA_W-1:0] dt, input logic l);
    WVALID = v; WREADY = rd; WDATA = dt; WLAST = l;
  endtask
  task automatic set_b(input logic v, input logic rd, input logic [1:0] rs);
    BVALID = v; BREADY = rd; BRESP = rs;
  endtask
  task automatic set_ar(input logic v, input logic rd, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    ARVALID = v; ARREADY = rd; ARADDR = a; ARLEN = l;
  endtask
  task automatic set_r(input logic v, input logic rd, input logic [DATA_W-1:0] dt, input logic [1:0] rs, input logic l);
    RVALID = v; RREADY = rd; RDATA = dt; RRESP = rs; RLAST = l;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 64'(err_flags), 64'h0);
    chk({tag, "_pulse"}, 64'(err_pulse), 64'h0);
    chk({tag, "_wr"}, 64'(wr_done_cnt), 64'h0);
    chk({tag, "_rd"}, 64'(rd_done_cnt), 64'h0);
  endtask

  task automatic do_reset();
    idle();
    ARESETn = 0;
    #1;
    model_reset();
    check_zero("rst");
    step();
    step();
    ARESETn = 1;
  endtask

  task automatic write_burst4();
    idle(); set_aw(1, 1, 32'h40, 8'd3); step();
    for (int i = 0; i < 4; i++) begin
      idle(); set_w(1, 1, DATA_W'(i + 1), i == 3); step();
    end
    idle(); step(); step();
    set_b(1, 1, 2'b00); step();
    idle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    idle();
    ARESETn = 0;
    model_reset();
    #3;
    check_zero("init");

    do_reset();
    write_burst4();
    chk("r19_flags", 64'(err_flags), 64'h0);
    chk("r19_wr", 64'(wr_done_cnt), 64'h1);

    do_reset();
    set_aw(1, 0, 32'h100, 8'd0); step();
    set_aw(1, 1, 32'h104, 8'd0); step();
    chk("r20_flags", 64'(err_flags), 64'h1);
    chk("r20_pulse", 64'(err_pulse), 64'h1);
    idle(); step();
    chk("r20_pulse_off", 64'(err_pulse), 64'h0);
    chk("r20_sticky", 64'(err_flags), 64'h1);
    err_clr = 1; step(); err_clr = 0;
    chk("r20_clr", 64'(err_flags), 64'h0);

    do_reset();
    set_ar(1, 1, 32'h200, 8'd1); step();
    idle(); set_r(1, 1, 32'hA5, 2'b00, 1); step();
    chk("r21_flags", 64'(err_flags), 64'h200);
    chk("r21_rd1", 64'(rd_done_cnt), 64'h1);
    idle(); set_ar(1, 1, 32'h204, 8'd0); step();
    idle(); set_r(1, 1, 32'h5A, 2'b00, 1); step();
    chk("r21_pulse", 64'(err_pulse), 64'h0);
    chk("r21_flags2", 64'(err_flags), 64'h200);
    chk("r21_rd2", 64'(rd_done_cnt), 64'h2);

    do_reset();
    set_aw(1, 1, 32'h0, 8'd0); set_w(1, 1, 32'h5, 1); step();
    idle();
    repeat (B_TIMEOUT - 1) step();
    chk("r22_early", 64'(err_flags), 64'h0);
    step();
    chk("r22_flags", 64'(err_flags), 64'h80);
    chk("r22_pulse", 64'(err_pulse), 64'h1);
    step();
    chk("r22_once", 64'(err_pulse), 64'h0);
    repeat (3) step();
    chk("r22_hold", 64'(err_pulse), 64'h0);
    set_b(1, 1, 2'b00); step();
    chk("r22_wr", 64'(wr_done_cnt), 64'h1);
    idle();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); set_aw(1, 1, ADDR_W'(i * 4), 8'd0); step();
    end
    chk("r23_four", 64'(err_flags), 64'h0);
    idle(); set_aw(1, 1, 32'h10, 8'd0); step();
    chk("r23_fifth", 64'(err_flags), 64'h40);
    idle(); set_r(1, 0, 32'h0, 2'b01, 0); step();
    chk("r23_resp", 64'(err_flags), 64'h140);

    do_reset();
    idle(); set_aw(1, 1, 32'h80, 8'd3); step();
    idle(); set_w(1, 1, 32'h1, 0); step();
    idle(); set_w(1, 1, 32'h2, 0); step();
    idle();
    #2;
    ARESETn = 0;
    #1;
    model_reset();
    check_zero("r24_mid");
    step();
    ARESETn = 1;
    write_burst4();
    chk("r24_flags", 64'(err_flags), 64'h0);
    chk("r24_wr", 64'(wr_done_cnt), 64'h1);

    do_reset();
    repeat (600) begin
      AWVALID = 1'($urandom_range(0, 1)); AWREADY = 1'($urandom_range(0, 1));
      AWADDR = ADDR_W'($urandom_range(0, 1) * 4); AWLEN = 8'($urandom_range(0, 2));
      WVALID = 1'($urandom_range(0, 1)); WREADY = ($urandom_range(0, 9) < 7);
      WDATA = DATA_W'($urandom_range(0, 1)); WLAST = ($urandom_range(0, 9) < 4);
      BVALID = 1'($urandom_range(0, 1)); BREADY = ($urandom_range(0, 9) < 7);
      BRESP = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      ARVALID = 1'($urandom_range(0, 1)); ARREADY = 1'($urandom_range(0, 1));
      ARADDR = ADDR_W'($urandom_range(0, 1) * 4); ARLEN = 8'($urandom_range(0, 2));
      RVALID = 1'($urandom_range(0, 1)); RREADY = ($urandom_range(0, 9) < 7);
      RDATA = DATA_W'($urandom_range(0, 1)); RLAST = ($urandom_range(0, 9) < 4);
      RRESP = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      err_clr = ($urandom_range(0, 4) == 0);
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_protocol_checker.md
AXI4_PROTOCOL_CHECKER -- requirements
Module: axi4_protocol_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDR_W, 32, AWADDR/ARADDR width
  DATA_W, 32, WDATA/RDATA width
  MAX_OUT, 4, outstanding bursts tracked per direction (power of 2, >=2)
  B_TIMEOUT, 16, max cycles from last W handshake to BVALID
  CNT_W, 16, completion counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
  ACLK  in  1  sole clock, rising edge
  ARESETn  in  1  asynchronous active-low reset
  AWVALID/AWREADY  in  1 each  write-address handshake
  AWADDR  in  ADDR_W; AWLEN  in  8  write address, beats-1
  WVALID/WREADY/WLAST  in  1 each  write-data handshake, last beat
  WDATA  in  DATA_W  write data
  BVALID/BREADY  in  1 each; BRESP  in  2  write response
  ARVALID/ARREADY  in  1 each; ARADDR  in  ADDR_W; ARLEN  in  8  read address
  RVALID/RREADY/RLAST  in  1 each; RDATA  in  DATA_W; RRESP  in  2  read data
  err_clr  in  1  clear sticky error flags
  err_flags  out  10  sticky error bits (REQ-010)
  err_pulse  out  1  one-cycle strobe on any newly detected error
  wr_done_cnt  out  CNT_W  completed write bursts
  rd_done_cnt  out  CNT_W  completed read bursts
REQ-003 The block SHALL be passive; all bus ports SHALL be inputs.

Function
REQ-004 Handshake on channel X SHALL mean XVALID && XREADY at a rising ACLK edge.
REQ-005 Stall on X SHALL mean XVALID && !XREADY; the cycle after a stall, XVALID SHALL be high and the payload (AW: AWADDR,AWLEN; W: WDATA,WLAST; AR: ARADDR,ARLEN; R: RDATA,RRESP,RLAST; B: BRESP) SHALL equal the stalled value, else the channel's stability bit sets.
REQ-006 Write queue: MAX_OUT-deep FIFO of AWLEN, pushed on AW handshake; W beat counter compares against head; pop on W handshake with WLAST.
REQ-007 W handshake with write queue empty and concurrent AW handshake SHALL use the incoming AWLEN (bypass); with queue empty and no AW handshake SHALL set bit 6 and not update the beat counter.
REQ-008 Read queue: MAX_OUT-deep FIFO of ARLEN, pushed on AR handshake, popped on R handshake with RLAST; R beat counter compares against head; R handshake with queue empty and no concurrent AR handshake sets bit 9.
REQ-009 Pending-B counter (width clog2(MAX_OUT)+1) SHALL increment on W-last pop, decrement on B handshake; both same cycle leaves it unchanged; B handshake at zero sets bit 9 and does not decrement.
REQ-010 err_flags bits: 0 AW stability; 1 W stability; 2 AR stability; 3 R stability; 4 B stability; 5 WLAST asserted on beat != head AWLEN or deasserted on beat == head AWLEN; 6 W without AW, or AW handshake with write queue full and no same-cycle pop (push dropped); 7 B timeout; 8 BRESP or RRESP in {01,11} while valid; 9 RLAST/ARLEN mismatch, R without AR, AR push to full read queue without same-cycle pop, or B without pending write.
REQ-011 On bit-5/9 length mismatch the burst SHALL still be popped on the last-flagged beat (WLAST/RLAST) so tracking resynchronises.
REQ-012 B timer SHALL count cycles while pending-B > 0 and !BVALID, reset to 0 on B handshake or when pending-B is 0, set bit 7 when reaching B_TIMEOUT, then hold (no repeat) until reset.
REQ-013 err_flags SHALL be sticky; err_clr clears all bits; a new error detected in the err_clr cycle SHALL remain set.
REQ-014 err_pulse SHALL be high exactly the cycle after any error condition is detected (registered), regardless of prior sticky state.
REQ-015 wr_done_cnt SHALL increment on each B handshake with pending-B > 0; rd_done_cnt on each R handshake with RLAST and non-empty read queue (or bypass); both wrap modulo 2^CNT_W.
REQ-016 Error detection latency SHALL be one cycle: flags/counters update on the edge following the offending sample.

Reset
REQ-017 ARESETn low SHALL asynchronously clear err_flags, err_pulse, both counters, both queues, beat counters, pending-B, B timer and stall history; mid-burst reset discards all in-flight tracking and raises no error.
REQ-018 First edge after ARESETn release SHALL treat no channel as previously stalled.

Verification
REQ-019 AW AWLEN=3, four W beats WLAST on 4th, B OKAY 2 cycles later -> err_flags=0, wr_done_cnt=1.
REQ-020 AWVALID high, AWREADY low, next cycle AWADDR changes 0x100->0x104 -> err_flags[0]=1, err_pulse one cycle; err_clr -> err_flags=0.
REQ-021 AR ARLEN=1, R beats RLAST on first beat -> err_flags[9]=1, queue popped; subsequent AR ARLEN=0, one R RLAST -> no new error, rd_done_cnt=2.
REQ-022 W last handshake, BVALID held low 16 cycles (B_TIMEOUT=16) -> err_flags[7]=1 once; late B handshake -> wr_done_cnt increments.
REQ-023 Five AW handshakes with no W (MAX_OUT=4) -> err_flags[6]=1 on fifth; RVALID with RRESP=01 -> err_flags[8]=1.
REQ-024 ARESETn low mid write burst (beat 2 of 4) then normal burst -> all outputs 0 during reset, no errors after.
